// File: rtl/clock_div_meter_if.sv
// Measurement bus between the divided-clock meter and its consumer.
// The meter (master) drives the results and the consumer (slave) drives enable and the clock under test.
interface clock_div_meter_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             meas_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic [2:0]       div_factor;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    modport master (
        input  enable,
        input  meas_in,
        output period,
        output high_time,
        output div_factor,
        output meas_valid,
        output locked,
        output timeout
    );

    modport slave (
        output enable,
        output meas_in,
        input  period,
        input  high_time,
        input  div_factor,
        input  meas_valid,
        input  locked,
        input  timeout
    );
endinterface

// File: rtl/clock_div_meter.sv
// Measures period and high time of a divided clock and recovers its divide factor.
// It also flags lock on a stable period and timeout when the input stops toggling.
module clock_div_meter #(
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    clock_div_meter_if.master bus
);
    localparam int               MW       = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT);
    localparam logic [MW-1:0]    LOCK_LIM = MW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Generator high phase is factor+2 cycles; difference taken one bit wider to catch underflow.
    function automatic logic [2:0] clamp_div(input logic [CNT_W-1:0] h);
        logic [CNT_W:0] d;
        d = {1'b0, h} - (CNT_W+1)'(2);
        if (d[CNT_W]) begin
            return 3'd0;
        end else if (d > (CNT_W+1)'(7)) begin
            return 3'd7;
        end else begin
            return d[2:0];
        end
    endfunction

    state_t           state_r;
    logic             meas_ff1_r;
    logic             meas_s_r;
    logic             meas_d_r;
    logic [CNT_W-1:0] per_cnt_r;
    logic [CNT_W-1:0] hi_cnt_r;
    logic [MW-1:0]    match_r;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] high_r;
    logic [2:0]       div_r;
    logic             valid_r;
    logic             locked_r;
    logic             timeout_r;

    logic             rise_s;
    logic [CNT_W-1:0] per_inc_s;
    logic [CNT_W-1:0] hi_inc_s;
    logic [MW-1:0]    match_next_s;
    logic             lock_next_s;
    logic             expire_s;

    // Next-value helpers for the counters and the match tracker.
    always_comb begin
        rise_s    = meas_s_r & ~meas_d_r;
        per_inc_s = sat_inc(per_cnt_r);
        hi_inc_s  = sat_inc(hi_cnt_r);
        expire_s  = (per_inc_s >= TO_LIM);
        if (per_inc_s == period_r) begin
            if (match_r >= LOCK_LIM) begin
                match_next_s = LOCK_LIM;
            end else begin
                match_next_s = match_r + MW'(1);
            end
        end else begin
            match_next_s = MW'(1);
        end
        lock_next_s = (match_next_s >= LOCK_LIM);
    end

    // Two-flop synchronizer plus edge-detect delay for the asynchronous input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meas_ff1_r <= 1'b0;
            meas_s_r   <= 1'b0;
            meas_d_r   <= 1'b0;
        end else begin
            meas_ff1_r <= bus.meas_in;
            meas_s_r   <= meas_ff1_r;
            meas_d_r   <= meas_s_r;
        end
    end

    // Measurement FSM with counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            per_cnt_r <= '0;
            hi_cnt_r  <= '0;
            match_r   <= '0;
            period_r  <= '0;
            high_r    <= '0;
            div_r     <= 3'd0;
            valid_r   <= 1'b0;
            locked_r  <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (!bus.enable) begin
                state_r   <= ST_IDLE;
                per_cnt_r <= '0;
                hi_cnt_r  <= '0;
                match_r   <= '0;
                period_r  <= '0;
                high_r    <= '0;
                div_r     <= 3'd0;
                locked_r  <= 1'b0;
                timeout_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r   <= ST_ARM;
                        per_cnt_r <= '0;
                        hi_cnt_r  <= '0;
                    end
                    ST_ARM: begin
                        if (rise_s) begin
                            state_r   <= ST_MEASURE;
                            per_cnt_r <= '0;
                            hi_cnt_r  <= CNT_W'(1);
                            timeout_r <= 1'b0;
                        end else if (expire_s) begin
                            timeout_r <= 1'b1;
                            locked_r  <= 1'b0;
                            match_r   <= '0;
                            per_cnt_r <= '0;
                        end else begin
                            per_cnt_r <= per_inc_s;
                        end
                    end
                    ST_MEASURE, ST_LOCKED: begin
                        if (rise_s) begin
                            // The rise cycle itself belongs to the new period and is high.
                            valid_r   <= 1'b1;
                            period_r  <= per_inc_s;
                            high_r    <= hi_cnt_r;
                            div_r     <= clamp_div(hi_cnt_r);
                            match_r   <= match_next_s;
                            locked_r  <= lock_next_s;
                            state_r   <= lock_next_s ? ST_LOCKED : ST_MEASURE;
                            per_cnt_r <= '0;
                            hi_cnt_r  <= CNT_W'(1);
                        end else if (expire_s) begin
                            state_r   <= ST_ARM;
                            timeout_r <= 1'b1;
                            locked_r  <= 1'b0;
                            match_r   <= '0;
                            per_cnt_r <= '0;
                            hi_cnt_r  <= '0;
                        end else begin
                            per_cnt_r <= per_inc_s;
                            hi_cnt_r  <= meas_s_r ? hi_inc_s : hi_cnt_r;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.period     = period_r;
    assign bus.high_time  = high_r;
    assign bus.div_factor = div_r;
    assign bus.meas_valid = valid_r;
    assign bus.locked     = locked_r;
    assign bus.timeout    = timeout_r;
endmodule
